// File: rtl/id_register_file_pkg.sv
// Shared constants and types for the ID-stage register bank and its
// debug dump port. REG_RA is also the JAL destination used by the WB mux.
package id_register_file_pkg;

   localparam int NB_DATA = 32;
   localparam int REGS    = 5;
   localparam int N_REGS  = 32;

   localparam logic [REGS-1:0] REG_RA   = 5'd31;
   localparam logic [REGS-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_SEND = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_t;

endpackage

// File: rtl/id_register_file_if.sv
// Dump handshake between the register bank (slave) and the debug unit
// (master). The debug unit requests a dump and paces it with ready.
interface id_register_file_if #(
   parameter int NB_DATA = id_register_file_pkg::NB_DATA,
   parameter int REGS    = id_register_file_pkg::REGS
);

   logic               i_dump_start;
   logic               i_dump_ready;
   logic               o_dump_valid;
   logic [REGS-1:0]    o_dump_addr;
   logic [NB_DATA-1:0] o_dump_dato;
   logic               o_dump_done;
   logic               o_busy;

   modport slave (
      input  i_dump_start,
      input  i_dump_ready,
      output o_dump_valid,
      output o_dump_addr,
      output o_dump_dato,
      output o_dump_done,
      output o_busy
   );

   modport master (
      output i_dump_start,
      output i_dump_ready,
      input  o_dump_valid,
      input  o_dump_addr,
      input  o_dump_dato,
      input  o_dump_done,
      input  o_busy
   );

endinterface

// File: rtl/id_register_file_dump_fsm.sv
// Sequencer that walks register indices 0..N_REGS-1 under a valid/ready
// handshake, then emits a single-cycle done pulse. Only the index is
// produced here; the top looks the word up in the array.
module regfile_dump_fsm #(
   parameter int REGS   = id_register_file_pkg::REGS,
   parameter int N_REGS = id_register_file_pkg::N_REGS
) (
   input  logic            i_clock,
   input  logic            i_reset,
   input  logic            i_dump_start,
   input  logic            i_dump_ready,
   output logic            o_dump_valid,
   output logic [REGS-1:0] o_dump_addr,
   output logic            o_dump_done,
   output logic            o_busy
);

   import id_register_file_pkg::*;

   localparam logic [REGS-1:0] LAST_IDX = REGS'(N_REGS - 1);

   dump_state_t     state;
   logic [REGS-1:0] idx;

   // State, index and all handshake outputs are registered together so
   // valid/done/busy never glitch relative to the state they describe.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state        <= DUMP_IDLE;
         idx          <= '0;
         o_dump_valid <= 1'b0;
         o_dump_done  <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         case (state)
            DUMP_IDLE: begin
               if (i_dump_start) begin
                  state        <= DUMP_SEND;
                  idx          <= '0;
                  o_dump_valid <= 1'b1;
                  o_busy       <= 1'b1;
               end
            end
            DUMP_SEND: begin
               if (i_dump_ready) begin
                  if (idx == LAST_IDX) begin
                     state        <= DUMP_DONE;
                     o_dump_valid <= 1'b0;
                     o_dump_done  <= 1'b1;
                  end else begin
                     idx <= idx + REGS'(1);
                  end
               end
            end
            DUMP_DONE: begin
               state       <= DUMP_IDLE;
               idx         <= '0;
               o_dump_done <= 1'b0;
               o_busy      <= 1'b0;
            end
            default: begin
               state        <= DUMP_IDLE;
               idx          <= '0;
               o_dump_valid <= 1'b0;
               o_dump_done  <= 1'b0;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

   assign o_dump_addr = idx;

endmodule

// File: rtl/id_register_file.sv
// MIPS ID-stage general-purpose register bank: two combinational read
// ports with WB write-through bypass, one write port gated by the debug
// step enable, and a handshaked sequential dump port for the debug unit.
module id_register_file #(
   parameter int NB_DATA = id_register_file_pkg::NB_DATA,
   parameter int REGS    = id_register_file_pkg::REGS,
   parameter int N_REGS  = id_register_file_pkg::N_REGS
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_step,
   input  logic [REGS-1:0]      i_RS,
   input  logic [REGS-1:0]      i_RT,
   input  logic [REGS-1:0]      i_RD,
   input  logic                 i_RegWrite,
   input  logic [NB_DATA-1:0]   i_dato,
   output logic [NB_DATA-1:0]   o_dato_RS,
   output logic [NB_DATA-1:0]   o_dato_RT,
   id_register_file_if.slave    dump
);

   import id_register_file_pkg::*;

   logic [NB_DATA-1:0] regs [N_REGS];
   logic               wr_en;
   logic               dump_valid;
   logic [REGS-1:0]    dump_addr;
   logic               dump_done;
   logic               dump_busy;

   // r0 is never written, so the array entry stays zero as well.
   assign wr_en = i_step && i_RegWrite && (i_RD != REG_ZERO);

   // Array update; reset clears every register so a post-reset dump is all zero.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[i_RD] <= i_dato;
      end
   end

   // Same-cycle bypass makes the WB write visible to ID, as if the write
   // happened in the first half of the cycle and the read in the second.
   assign o_dato_RS = (i_RS == REG_ZERO)           ? '0     :
                      (wr_en && (i_RS == i_RD))    ? i_dato :
                                                     regs[i_RS];
   assign o_dato_RT = (i_RT == REG_ZERO)           ? '0     :
                      (wr_en && (i_RT == i_RD))    ? i_dato :
                                                     regs[i_RT];

   regfile_dump_fsm #(
      .REGS   (REGS),
      .N_REGS (N_REGS)
   ) u_dump_fsm (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_dump_start (dump.i_dump_start),
      .i_dump_ready (dump.i_dump_ready),
      .o_dump_valid (dump_valid),
      .o_dump_addr  (dump_addr),
      .o_dump_done  (dump_done),
      .o_busy       (dump_busy)
   );

   // Dump word reads the stored value only (no bypass), so a write landing
   // on the current index during a stall shows up one cycle later.
   assign dump.o_dump_valid = dump_valid;
   assign dump.o_dump_addr  = dump_addr;
   assign dump.o_dump_dato  = dump_valid ? regs[dump_addr] : '0;
   assign dump.o_dump_done  = dump_done;
   assign dump.o_busy       = dump_busy;

endmodule

// File: tb/tb_id_register_file.sv
// Bench for id_register_file: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle to a behavioural model.
module tb_id_register_file;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_step;
   logic [4:0]  i_RS, i_RT, i_RD;
   logic        i_RegWrite;
   logic [31:0] i_dato;
   logic [31:0] o_dato_RS, o_dato_RT;

   id_register_file_if dif ();

   id_register_file dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_step     (i_step),
      .i_RS       (i_RS),
      .i_RT       (i_RT),
      .i_RD       (i_RD),
      .i_RegWrite (i_RegWrite),
      .i_dato     (i_dato),
      .o_dato_RS  (o_dato_RS),
      .o_dato_RT  (o_dato_RT),
      .dump       (dif.slave)
   );

   always #5 i_clock = ~i_clock;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model state: register contents, dump progress, pending done pulse.
   logic [31:0] mem [32];
   bit          d_active = 1'b0;
   int          d_next   = 0;
   bit          d_done   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change only 1ns after a rising edge, so at the falling edge they
   // hold exactly what the next rising edge will sample: compare first, then
   // advance the model across that upcoming edge.
   always @(negedge i_clock) begin
      logic [31:0] e_rs, e_rt;
      bit          wc, was_done;
      wc   = i_step && i_RegWrite && (i_RD != 5'd0);
      e_rs = (i_RS == 5'd0) ? 32'd0 : ((wc && i_RS == i_RD) ? i_dato : mem[i_RS]);
      e_rt = (i_RT == 5'd0) ? 32'd0 : ((wc && i_RT == i_RD) ? i_dato : mem[i_RT]);
      if (chk_en) begin
         chk("m_rs", o_dato_RS, e_rs);
         chk("m_rt", o_dato_RT, e_rt);
         chk("m_valid", 32'(dif.o_dump_valid), 32'(d_active));
         chk("m_done",  32'(dif.o_dump_done),  32'(d_done));
         chk("m_busy",  32'(dif.o_busy),       32'(d_active || d_done));
         if (d_active) begin
            chk("m_addr", 32'(dif.o_dump_addr), 32'(d_next));
            chk("m_dato", dif.o_dump_dato, mem[d_next]);
         end
      end
      if (i_reset) begin
         foreach (mem[i]) mem[i] = 32'd0;
         d_active = 1'b0;
         d_next   = 0;
         d_done   = 1'b0;
      end else begin
         was_done = d_done;
         d_done   = 1'b0;
         if (d_active) begin
            if (dif.i_dump_ready) begin
               if (d_next == 31) begin
                  d_active = 1'b0;
                  d_done   = 1'b1;
               end else begin
                  d_next++;
               end
            end
         end else if (!was_done && dif.i_dump_start) begin
            d_active = 1'b1;
            d_next   = 0;
         end
         if (wc) mem[i_RD] = i_dato;
      end
   end

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   initial begin
      int exp_addr;
      bit seen;
      i_reset = 1'b1; i_step = 1'b0; i_RegWrite = 1'b0;
      i_RS = '0; i_RT = '0; i_RD = '0; i_dato = '0;
      dif.i_dump_start = 1'b0; dif.i_dump_ready = 1'b0;
      repeat (3) tick();
      i_reset = 1'b0;
      chk_en  = 1'b1;

      // Reset state
      i_RS = 5'd3; i_RT = 5'd31;
      @(negedge i_clock);
      chk("rst_rs3", o_dato_RS, 32'd0);
      chk("rst_rt31", o_dato_RT, 32'd0);
      chk("rst_busy", 32'(dif.o_busy), 32'd0);
      chk("rst_valid", 32'(dif.o_dump_valid), 32'd0);
      chk("rst_addr", 32'(dif.o_dump_addr), 32'd0);
      chk("rst_dato", dif.o_dump_dato, 32'd0);

      // JAL write of PC+8 to r31, bypass then stored read
      tick();
      i_step = 1'b1; i_RegWrite = 1'b1; i_RD = 5'd31; i_dato = 32'h48; i_RS = 5'd31; i_RT = 5'd3;
      @(negedge i_clock);
      chk("jal_bypass_rs", o_dato_RS, 32'h48);
      chk("jal_rt3", o_dato_RT, 32'd0);
      tick();
      i_RegWrite = 1'b0; i_RS = 5'd0; i_RT = 5'd31;
      @(negedge i_clock);
      chk("jal_stored_rt", o_dato_RT, 32'h48);

      // Write to r0 is discarded
      tick();
      i_RegWrite = 1'b1; i_RD = 5'd0; i_dato = 32'hDEAD_BEEF; i_RS = 5'd0;
      @(negedge i_clock);
      chk("r0_wr_cycle", o_dato_RS, 32'd0);
      tick();
      i_RegWrite = 1'b0;
      @(negedge i_clock);
      chk("r0_after", o_dato_RS, 32'd0);

      // step=0 freezes the array
      tick();
      i_step = 1'b0; i_RegWrite = 1'b1; i_RD = 5'd5; i_dato = 32'h1234; i_RS = 5'd5;
      @(negedge i_clock);
      chk("nostep_bypass", o_dato_RS, 32'd0);
      tick();
      i_step = 1'b1; i_RegWrite = 1'b0;
      @(negedge i_clock);
      chk("nostep_r5", o_dato_RS, 32'd0);

      // Preload r_n = 4n
      for (int n = 1; n < 32; n++) begin
         tick();
         i_RegWrite = 1'b1; i_RD = 5'(n); i_dato = 32'(n * 4);
      end
      tick();
      i_RegWrite = 1'b0;

      // Full-rate dump
      dif.i_dump_ready = 1'b1; dif.i_dump_start = 1'b1;
      tick();
      dif.i_dump_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         @(negedge i_clock);
         chk("dump_valid", 32'(dif.o_dump_valid), 32'd1);
         chk("dump_addr", 32'(dif.o_dump_addr), 32'(k));
         chk("dump_dato", dif.o_dump_dato, 32'(k * 4));
         tick();
      end
      @(negedge i_clock);
      chk("dump_done", 32'(dif.o_dump_done), 32'd1);
      chk("dump_done_valid", 32'(dif.o_dump_valid), 32'd0);
      chk("dump_done_busy", 32'(dif.o_busy), 32'd1);
      tick();
      @(negedge i_clock);
      chk("dump_after_done", 32'(dif.o_dump_done), 32'd0);
      chk("dump_after_busy", 32'(dif.o_busy), 32'd0);

      // Stalled dump (ready 1,0,0,1), random writes, ignored restart requests
      dif.i_dump_start = 1'b1;
      tick();
      dif.i_dump_start = 1'b0;
      exp_addr = 0;
      seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         dif.i_dump_ready = ((c % 4) == 0) || ((c % 4) == 3);
         dif.i_dump_start = ($urandom_range(0, 7) == 0);
         i_RegWrite = $urandom_range(0, 1);
         i_RD = ($urandom_range(0, 2) == 0) ? 5'(exp_addr) : 5'($urandom_range(0, 31));
         i_dato = $urandom;
         i_RS = 5'($urandom_range(0, 31));
         i_RT = i_RD;
         @(negedge i_clock);
         if (dif.o_dump_done) begin
            seen = 1'b1;
         end else if (dif.o_dump_valid) begin
            chk("stall_addr", 32'(dif.o_dump_addr), 32'(exp_addr));
            if (dif.i_dump_ready) exp_addr++;
         end
         if (!seen) tick();
      end
      chk("stall_done_seen", 32'(seen), 32'd1);
      chk("stall_word_count", 32'(exp_addr), 32'd32);
      tick();
      i_RegWrite = 1'b0; dif.i_dump_start = 1'b0;

      // Reset while word 10 is on the port
      dif.i_dump_ready = 1'b1; dif.i_dump_start = 1'b1;
      tick();
      dif.i_dump_start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         @(negedge i_clock);
         if (dif.o_dump_valid && dif.o_dump_addr == 5'd9) seen = 1'b1;
         tick();
      end
      chk("midrst_reach_addr", 32'(seen), 32'd1);
      i_reset = 1'b1;
      @(negedge i_clock);
      chk("midrst_addr10", 32'(dif.o_dump_addr), 32'd10);
      tick();
      i_reset = 1'b0; i_step = 1'b0;
      @(negedge i_clock);
      chk("midrst_valid", 32'(dif.o_dump_valid), 32'd0);
      chk("midrst_busy", 32'(dif.o_busy), 32'd0);
      chk("midrst_done", 32'(dif.o_dump_done), 32'd0);
      for (int k = 0; k < 32; k++) begin
         tick();
         i_RS = 5'(k); i_RT = 5'(31 - k);
         @(negedge i_clock);
         chk("midrst_clear_rs", o_dato_RS, 32'd0);
         chk("midrst_clear_rt", o_dato_RT, 32'd0);
      end

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         i_reset = ($urandom_range(0, 299) == 0);
         i_step = ($urandom_range(0, 3) != 0);
         i_RegWrite = $urandom_range(0, 1);
         i_RD = 5'($urandom_range(0, 31));
         i_dato = $urandom;
         i_RS = ($urandom_range(0, 3) == 0) ? i_RD : 5'($urandom_range(0, 31));
         i_RT = ($urandom_range(0, 3) == 0) ? i_RD : 5'($urandom_range(0, 31));
         dif.i_dump_start = ($urandom_range(0, 19) == 0);
         dif.i_dump_ready = $urandom_range(0, 1);
      end
      tick();
      @(negedge i_clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
